// File: rtl/paddle_responder_if.sv
// Player-pin signal bundle between the board top and paddle_responder.
interface paddle_responder_if;
    logic       dwn;
    logic [7:0] position;
    logic       quad_a;
    logic       quad_b;
    logic       pin_low;
    logic       busy;
    logic [7:0] pos_out;

    // Board side: drives the chip request and the paddle inputs
    modport master (
        output dwn, position, quad_a, quad_b,
        input  pin_low, busy, pos_out
    );

    // Responder side
    modport slave (
        input  dwn, position, quad_a, quad_b,
        output pin_low, busy, pos_out
    );
endinterface

// File: rtl/paddle_responder.sv
// Paddle (pot + RC) emulator for one AY-3-8500 player input.
// Holds the player pin low for (MIN_COUNT + position) * PRESCALE cycles
// after the chip releases its discharge request.
// PADDLE_QUAD_EN: position from quadrature encoder phases.
module paddle_responder #(
    parameter int unsigned PRESCALE  = 8,
    parameter int unsigned MIN_COUNT = 32,
    parameter int unsigned POS_RESET = 128
) (
    input  logic                 CLK,
    input  logic                 reset,
    paddle_responder_if.slave    bus
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CW = 10;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISCHARGE,
        S_CHARGE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_nxt;
    logic [CW-1:0]   r_unit;
    logic [CW-1:0]   w_unit_nxt;
    logic [CW-1:0]   w_unit_inc;
    logic [CW-1:0]   r_target;
    logic [CW-1:0]   w_target_nxt;
    logic            r_pin_low;
    logic            w_pin_low_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic [7:0]      r_pos;
    logic            w_unused;

    assign w_unit_inc  = r_unit + CW'(1);
    assign bus.pin_low = r_pin_low;
    assign bus.busy    = r_busy;
    assign bus.pos_out = r_pos;

    // State, counters and registered pin outputs
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_unit    <= '0;
            r_target  <= '0;
            r_pin_low <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_unit    <= w_unit_nxt;
            r_target  <= w_target_nxt;
            r_pin_low <= w_pin_low_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next state, charge timing and next output values
    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = r_presc;
        w_unit_nxt   = r_unit;
        w_target_nxt = r_target;

        if (bus.dwn && (r_state != S_DISCHARGE)) begin
            // Chip restarted discharge: abandon any charge in progress
            w_state_nxt = S_DISCHARGE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    w_state_nxt = r_state;
                end
                S_DISCHARGE: begin
                    if (!bus.dwn) begin
                        w_state_nxt  = S_CHARGE;
                        w_target_nxt = CW'(MIN_COUNT) + CW'(r_pos);
                        w_presc_nxt  = '0;
                        w_unit_nxt   = '0;
                    end
                end
                S_CHARGE: begin
                    if (r_presc == PRE_LAST) begin
                        w_presc_nxt = '0;
                        w_unit_nxt  = w_unit_inc;
                        if (w_unit_inc == r_target) begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        w_pin_low_nxt = (w_state_nxt == S_DISCHARGE) || (w_state_nxt == S_CHARGE);
        w_busy_nxt    = (w_state_nxt == S_CHARGE);
    end

`ifdef PADDLE_QUAD_EN
    logic       r_qa_s1;
    logic       r_qa_s2;
    logic       r_qb_s1;
    logic       r_qb_s2;
    logic       r_qa_prev;
    logic       r_qb_prev;
    logic       w_step_up;
    logic       w_step_dn;

    assign w_unused = ^bus.position;

    // Two-flop synchronisers plus previous-phase register
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_qa_s1   <= 1'b0;
            r_qa_s2   <= 1'b0;
            r_qb_s1   <= 1'b0;
            r_qb_s2   <= 1'b0;
            r_qa_prev <= 1'b0;
            r_qb_prev <= 1'b0;
        end else begin
            r_qa_s1   <= bus.quad_a;
            r_qa_s2   <= r_qa_s1;
            r_qb_s1   <= bus.quad_b;
            r_qb_s2   <= r_qb_s1;
            r_qa_prev <= r_qa_s2;
            r_qb_prev <= r_qb_s2;
        end
    end

    // Gray-step decode on {a,b}: 00->01->11->10->00 is up; double changes ignored
    always_comb begin
        w_step_up = 1'b0;
        w_step_dn = 1'b0;
        case ({r_qa_prev, r_qb_prev, r_qa_s2, r_qb_s2})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: w_step_up = 1'b1;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: w_step_dn = 1'b1;
            default: begin
                w_step_up = 1'b0;
                w_step_dn = 1'b0;
            end
        endcase
    end

    // Saturating position register
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pos <= 8'(POS_RESET);
        end else if (w_step_up && (r_pos != 8'hFF)) begin
            r_pos <= r_pos + 8'd1;
        end else if (w_step_dn && (r_pos != 8'h00)) begin
            r_pos <= r_pos - 8'd1;
        end
    end
`else
    assign w_unused = bus.quad_a ^ bus.quad_b;

    // Direct position, registered once
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pos <= 8'h00;
        end else begin
            r_pos <= bus.position;
        end
    end
`endif

endmodule

// File: tb/tb_paddle_responder.sv
// Directed self-checking bench for paddle_responder (PRESCALE=4, MIN_COUNT=16).
module tb_paddle_responder;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    paddle_responder_if bus_if ();

    paddle_responder #(
        .PRESCALE  (4),
        .MIN_COUNT (16),
        .POS_RESET (254)
    ) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after dwn is dropped: counts pin_low and busy cycles of the charge
    task automatic measure(input int chg_at, input logic [7:0] chg_val,
                           output int len, output int blen);
        len  = 0;
        blen = 0;
        tick();
        while (bus_if.pin_low && len < 5000) begin
            if (bus_if.busy) blen++;
            len++;
            if (len == chg_at) bus_if.position = chg_val;
            tick();
        end
    endtask

    // Discharge pulse of 'hold' cycles followed by a measured charge
    task automatic pulse(input int hold, output int len, output int blen);
        bus_if.dwn = 1'b1;
        repeat (hold) tick();
        bus_if.dwn = 1'b0;
        measure(-1, 8'd0, len, blen);
    endtask

    initial begin
        int   len;
        int   blen;
        logic low_ok;

        n_checks        = 0;
        n_errors        = 0;
        reset           = 1'b1;
        bus_if.dwn      = 1'b0;
        bus_if.position = 8'd10;
        bus_if.quad_a   = 1'b0;
        bus_if.quad_b   = 1'b0;
        repeat (3) tick();

        check("rst_pin_low", int'(bus_if.pin_low), 0);
        check("rst_busy", int'(bus_if.busy), 0);
`ifdef PADDLE_QUAD_EN
        check("rst_pos_quad", int'(bus_if.pos_out), 254);
        reset = 1'b0;
        repeat (2) tick();

        // Forward step 00->01 with latency check
        bus_if.quad_b = 1'b1;
        repeat (2) tick();
        check("quad_lat_2", int'(bus_if.pos_out), 254);
        tick();
        check("quad_lat_3", int'(bus_if.pos_out), 255);
        // 01->11->10, saturating at 255
        bus_if.quad_a = 1'b1;
        repeat (4) tick();
        bus_if.quad_b = 1'b0;
        repeat (4) tick();
        check("quad_sat", int'(bus_if.pos_out), 255);
        // Reverse 10->11->01->00->10
        bus_if.quad_b = 1'b1; repeat (4) tick();
        bus_if.quad_a = 1'b0; repeat (4) tick();
        bus_if.quad_b = 1'b0; repeat (4) tick();
        bus_if.quad_a = 1'b1; repeat (4) tick();
        check("quad_rev4", int'(bus_if.pos_out), 251);
        // Illegal double change 10->01
        bus_if.quad_a = 1'b0;
        bus_if.quad_b = 1'b1;
        repeat (4) tick();
        check("quad_illegal", int'(bus_if.pos_out), 251);
        // Position must be ignored in quadrature mode
        bus_if.position = 8'd0;
        pulse(20, len, blen);
        check("quad_charge_len", len, (16 + 251) * 4);
        check("quad_charge_busy", blen, (16 + 251) * 4);
        reset = 1'b1;
        tick();
        check("quad_rst_pos", int'(bus_if.pos_out), 254);
        check("quad_rst_pin", int'(bus_if.pin_low), 0);
        reset = 1'b0;
        tick();
`else
        check("rst_pos_direct", int'(bus_if.pos_out), 0);
        reset = 1'b0;
        tick();
        check("pos_follow", int'(bus_if.pos_out), 10);

        // pin_low rises one cycle after dwn is first sampled
        bus_if.dwn = 1'b1;
        tick();
        check("rise_pin_low", int'(bus_if.pin_low), 1);
        check("rise_busy", int'(bus_if.busy), 0);
        repeat (19) tick();
        bus_if.dwn = 1'b0;
        measure(-1, 8'd0, len, blen);
        check("charge_len_10", len, 104);
        check("charge_busy_10", blen, 104);
        check("done_busy", int'(bus_if.busy), 0);

        // Boundary positions
        bus_if.position = 8'd0;
        pulse(20, len, blen);
        check("charge_len_0", len, 64);
        bus_if.position = 8'd255;
        pulse(20, len, blen);
        check("charge_len_255", len, 1084);

        // Re-assert dwn 30 cycles into CHARGE
        bus_if.position = 8'd10;
        low_ok = 1'b1;
        bus_if.dwn = 1'b1;
        repeat (20) tick();
        bus_if.dwn = 1'b0;
        tick();
        repeat (30) begin
            low_ok &= bus_if.pin_low;
            tick();
        end
        bus_if.dwn = 1'b1;
        repeat (5) begin
            tick();
            low_ok &= bus_if.pin_low;
        end
        bus_if.dwn = 1'b0;
        measure(-1, 8'd0, len, blen);
        check("reassert_no_drop", int'(low_ok), 1);
        check("reassert_len", len, 104);

        // Position change mid-CHARGE keeps latched target
        bus_if.dwn = 1'b1;
        repeat (20) tick();
        bus_if.dwn = 1'b0;
        measure(20, 8'd200, len, blen);
        check("midchg_len", len, 104);
        pulse(20, len, blen);
        check("next_len_200", len, 864);

        // Reset 50 cycles into CHARGE
        bus_if.dwn = 1'b1;
        repeat (20) tick();
        bus_if.dwn = 1'b0;
        repeat (50) tick();
        reset = 1'b1;
        tick();
        check("midrst_pin_low", int'(bus_if.pin_low), 0);
        check("midrst_busy", int'(bus_if.busy), 0);
        check("midrst_pos", int'(bus_if.pos_out), 0);
        reset = 1'b0;
        tick();
        check("postrst_pos", int'(bus_if.pos_out), 200);
        pulse(20, len, blen);
        check("postrst_len", len, 864);
        check("postrst_busy", blen, 864);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
